// File: rtl/serial_parallel_sync_ctrl_pkg.sv
// Shared constants for the 32f serial link: alignment symbol, sync states and
// default lock/loss thresholds used by both the receive and transmit sides.
package serial_parallel_sync_ctrl_pkg;

  localparam logic [7:0]  COM            = 8'hBC;
  localparam int unsigned LOCK_COUNT_DEF = 4;
  localparam int unsigned MAX_GAP_DEF    = 16;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    ALIGN  = 2'd1,
    LOCKED = 2'd2
  } sync_state_e;

endpackage

// File: rtl/serial_parallel_com_detect.sv
// Serial shift window and COM compare; nxt is the byte that includes the bit
// being sampled on the current edge.
module serial_parallel_com_detect
  import serial_parallel_sync_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       data_in,
  output logic [7:0] nxt,
  output logic       com_hit
);

  // Only the seven older bits need storage; the eighth is data_in itself.
  logic [6:0] hist;

  assign nxt     = {hist, data_in};
  assign com_hit = (nxt == COM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist <= '0;
    end else begin
      hist <= nxt[6:0];
    end
  end

endmodule

// File: rtl/serial_parallel_sync_ctrl.sv
// Receive-side sync controller: COM search, byte alignment, lock and loss of
// lock, with registered parallel byte output and byte-boundary strobe.
module serial_parallel_sync_ctrl
  import serial_parallel_sync_ctrl_pkg::*;
#(
  parameter int unsigned LOCK_COUNT = LOCK_COUNT_DEF,
  parameter int unsigned MAX_GAP    = MAX_GAP_DEF
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic       Data_in,
  output logic       active,
  output logic       byte_strobe,
  output logic [7:0] Data_out,
  output logic       valid_out,
  output logic [1:0] state_out
);

  localparam logic [3:0] LOCK_LAST = 4'(LOCK_COUNT - 1);
  localparam logic [7:0] GAP_LAST  = 8'(MAX_GAP - 1);

  sync_state_e state;
  logic [2:0]  bit_cnt;
  logic [3:0]  com_cnt;
  logic [7:0]  gap_cnt;
  logic [7:0]  nxt;
  logic        com_hit;

  serial_parallel_com_detect u_com_detect (
    .clk     (clk_32f),
    .rst_n   (reset),
    .data_in (Data_in),
    .nxt     (nxt),
    .com_hit (com_hit)
  );

  assign state_out = state;

  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      state       <= SEARCH;
      bit_cnt     <= '0;
      com_cnt     <= '0;
      gap_cnt     <= '0;
      active      <= 1'b0;
      byte_strobe <= 1'b0;
      Data_out    <= '0;
      valid_out   <= 1'b0;
    end else begin
      byte_strobe <= 1'b0;
      case (state)
        SEARCH: begin
          active    <= 1'b0;
          valid_out <= 1'b0;
          Data_out  <= '0;
          if (com_hit) begin
            state   <= ALIGN;
            bit_cnt <= '0;
            com_cnt <= 4'd1;
          end
        end
        ALIGN: begin
          active    <= 1'b0;
          valid_out <= 1'b0;
          Data_out  <= '0;
          bit_cnt   <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            if (com_hit) begin
              com_cnt <= com_cnt + 4'd1;
              if (com_cnt == LOCK_LAST) begin
                state   <= LOCKED;
                gap_cnt <= '0;
                active  <= 1'b1;
              end
            end else begin
              // A failed boundary byte is not reconsidered as a fresh COM.
              state   <= SEARCH;
              com_cnt <= '0;
            end
          end
        end
        LOCKED: begin
          active  <= 1'b1;
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            Data_out    <= nxt;
            valid_out   <= !com_hit;
            byte_strobe <= 1'b1;
            if (com_hit) begin
              gap_cnt <= '0;
            end else begin
              gap_cnt <= gap_cnt + 8'd1;
              if (gap_cnt == GAP_LAST) begin
                state   <= SEARCH;
                com_cnt <= '0;
              end
            end
          end
        end
        default: begin
          state     <= SEARCH;
          active    <= 1'b0;
          valid_out <= 1'b0;
          Data_out  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_parallel_sync_ctrl.sv
// Directed and randomized bit streams checked every edge against a byte-window
// reference model of the sync rules.
module tb_serial_parallel_sync_ctrl;

  localparam int LOCK = 4;
  localparam int GAP  = 16;
  localparam logic [7:0] COMB = 8'hBC;

  logic       clk_32f = 1'b0;
  logic       reset;
  logic       Data_in = 1'b0;
  logic       active, byte_strobe, valid_out;
  logic [7:0] Data_out;
  logic [1:0] state_out;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  int m_mode, m_hist, m_anchor, m_coms, m_gap, cyc;
  logic       e_active, e_strobe, e_valid;
  logic [7:0] e_data;

  always #5 clk_32f = ~clk_32f;

  serial_parallel_sync_ctrl #(.LOCK_COUNT(LOCK), .MAX_GAP(GAP)) dut (
    .clk_32f     (clk_32f),
    .reset       (reset),
    .Data_in     (Data_in),
    .active      (active),
    .byte_strobe (byte_strobe),
    .Data_out    (Data_out),
    .valid_out   (valid_out),
    .state_out   (state_out)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s at cycle %0d: observed %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_hist = 0; m_coms = 0; m_gap = 0; m_anchor = 0;
    e_active = 0; e_strobe = 0; e_valid = 0; e_data = '0;
  endtask

  // Mode 0 searches, 1 aligns, 2 is locked; byte boundaries are every 8th
  // bit counted from the edge where the first COM was seen.
  task automatic model_step(input logic b);
    bit byte_end;
    cyc++;
    m_hist   = ((m_hist << 1) | int'(b)) & 255;
    byte_end = ((cyc - m_anchor) % 8) == 0;
    e_strobe = 0;
    if (m_mode != 2) begin
      e_active = 0; e_valid = 0; e_data = '0;
    end
    if (m_mode == 0) begin
      if (m_hist == int'(COMB)) begin
        m_mode = 1; m_anchor = cyc; m_coms = 1;
      end
    end else if (m_mode == 1) begin
      if (byte_end) begin
        if (m_hist == int'(COMB)) begin
          m_coms++;
          if (m_coms == LOCK) begin
            m_mode = 2; m_gap = 0; e_active = 1;
          end
        end else begin
          m_mode = 0; m_coms = 0;
        end
      end
    end else begin
      e_active = 1;
      if (byte_end) begin
        e_strobe = 1;
        e_data   = 8'(m_hist);
        e_valid  = (m_hist != int'(COMB));
        if (m_hist == int'(COMB)) m_gap = 0;
        else begin
          m_gap++;
          if (m_gap == GAP) m_mode = 0;
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".state"},  {6'b0, state_out},   8'(m_mode));
    check({tag, ".active"}, {7'b0, active},      {7'b0, e_active});
    check({tag, ".strobe"}, {7'b0, byte_strobe}, {7'b0, e_strobe});
    check({tag, ".data"},   Data_out,            e_data);
    check({tag, ".valid"},  {7'b0, valid_out},   {7'b0, e_valid});
  endtask

  task automatic send_bit(input logic b, input string tag);
    Data_in = b;
    @(posedge clk_32f);
    #1;
    if (!reset) begin
      cyc++;
      model_reset();
    end else begin
      model_step(b);
    end
    check_all(tag);
  endtask

  task automatic send_byte(input logic [7:0] v, input string tag);
    for (int i = 7; i >= 0; i--) send_bit(v[i], tag);
  endtask

  initial begin
    cyc = 0;
    model_reset();
    reset = 1'b1;
    #2 reset = 1'b0;

    // Reset held with toggling data, then idle zeros
    for (int i = 0; i < 6; i++) send_bit(1'(i % 2), "rst_hold");
    reset = 1'b1;
    for (int i = 0; i < 40; i++) send_bit(1'b0, "rst_idle");

    // Lock acquisition after junk bits
    for (int i = 0; i < 3; i++) send_bit(1'($urandom_range(1)), "junk");
    for (int i = 0; i < 4; i++) send_byte(COMB, "acq_com");
    send_byte(8'h5A, "acq_5a");
    send_byte(8'h3C, "acq_3c");

    // COM inside LOCKED restarts the gap count
    send_byte(8'h11, "lk_11");
    send_byte(COMB,  "lk_com");
    send_byte(8'h22, "lk_22");
    send_byte(COMB,  "lk_com2");

    // Loss of lock after MAX_GAP payload bytes
    for (int i = 0; i < GAP; i++) send_byte(8'hA5, "loss_a5");
    check("loss_state", {6'b0, state_out}, 8'd0);
    send_bit(1'b0, "loss_next");
    check("loss_active", {7'b0, active}, 8'd0);
    for (int i = 0; i < 7; i++) send_bit(1'b0, "loss_pad");

    // Alignment break then a clean relock
    send_byte(COMB, "brk_com");
    send_byte(COMB, "brk_com");
    send_byte(8'h00, "brk_00");
    check("brk_state", {6'b0, state_out}, 8'd0);
    for (int i = 0; i < 4; i++) send_byte(COMB, "relock");
    check("relock_active", {7'b0, active}, 8'd1);

    // Randomized payload with occasional COMs while locked
    for (int i = 0; i < 40; i++) begin
      logic [7:0] v;
      v = ($urandom_range(2) == 0) ? COMB : 8'($urandom);
      send_byte(v, "rnd_byte");
    end

    // Random raw bits, including misaligned patterns, then relock
    for (int i = 0; i < 200; i++) send_bit(1'($urandom_range(1)), "rnd_bit");
    for (int i = 0; i < 4; i++) send_byte(COMB, "rnd_relock");
    for (int i = 0; i < 20; i++) begin
      logic [7:0] v;
      v = ($urandom_range(3) == 0) ? COMB : 8'($urandom);
      send_byte(v, "rnd_byte2");
    end
    for (int i = 0; i < 4; i++) send_byte(COMB, "pre_rst");

    // Asynchronous reset in the middle of the 4th bit of a data byte
    send_bit(1'b0, "mid_b1");
    send_bit(1'b1, "mid_b2");
    send_bit(1'b0, "mid_b3");
    Data_in = 1'b1;
    @(posedge clk_32f);
    #3 reset = 1'b0;
    #1;
    cyc++;
    model_reset();
    check_all("async_rst");
    send_bit(1'b1, "rst_low");
    reset = 1'b1;
    for (int i = 0; i < 3; i++) send_byte(COMB, "post_com");
    check("post_3com_active", {7'b0, active}, 8'd0);
    send_byte(COMB, "post_com4");
    check("post_4com_active", {7'b0, active}, 8'd1);
    send_byte(8'h77, "post_77");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
